// File: rtl/ddr3_test_gen_if.sv
// DDR3 user-side command/write/read bus between test generator and controller.
// master: cmd, cmd_en, addr, wr_data, wr_data_en, wr_data_end out; readies and read data in.
interface ddr3_test_gen_if #(
   parameter int ADDR_WIDTH = 28,
   parameter int DATA_WIDTH = 128
);
   logic [2:0]            cmd;
   logic                  cmd_en;
   logic                  cmd_ready;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_data_en;
   logic                  wr_data_end;
   logic                  wr_data_rdy;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_data_valid;

   modport master (
      output cmd, cmd_en, addr,
      output wr_data, wr_data_en, wr_data_end,
      input  cmd_ready, wr_data_rdy,
      input  rd_data, rd_data_valid
   );

   modport slave (
      input  cmd, cmd_en, addr,
      input  wr_data, wr_data_en, wr_data_end,
      output cmd_ready, wr_data_rdy,
      output rd_data, rd_data_valid
   );
endinterface

// File: rtl/ddr3_test_gen.sv
// DDR3 write-then-read-back test generator: writes NUM_BURSTS BL8 bursts at
// addr n*8, reads them back and counts mismatching beats.
// Ports: clk, rst (async high), init_calib_complete, start (rising edge),
// mem (master bus), busy/done/pass status, err_cnt (saturating), last_rd.
// Optional: define DDR3_TEST_LFSR_EN for a 16-bit LFSR data pattern
// (seed 16'hACE1) instead of the incrementing burst index.
module ddr3_test_gen #(
   parameter int ADDR_WIDTH = 28,
   parameter int DATA_WIDTH = 128,
   parameter int NUM_BURSTS = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            init_calib_complete,
   input  logic            start,
   ddr3_test_gen_if.master mem,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [15:0]     err_cnt,
   output logic [15:0]     last_rd
);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      CHECK,
      FINISH
   } state_t;

   localparam logic [2:0]  CMD_WR = 3'b000;
   localparam logic [2:0]  CMD_RD = 3'b001;
   localparam logic [15:0] LAST   = 16'(NUM_BURSTS - 1);
   localparam logic [15:0] NB     = 16'(NUM_BURSTS);

   state_t state, next_state;

   logic                  start_d;
   logic [15:0]           wr_idx;
   logic [15:0]           rd_idx;
   logic [15:0]           rx_cnt;
   logic                  cmd_acc;
   logic                  dat_acc;
   logic [2:0]            cmd_q;
   logic                  cmd_en_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wr_data_q;
   logic                  wr_en_q;

   logic start_rise;
   logic cmd_fire;
   logic dat_fire;
   logic burst_done;
   logic running;
   logic calib_lost;
   logic rx_take;
   logic [15:0] wr_next_word;
   logic [15:0] rd_exp_word;
   logic [15:0] seed_word;

   function automatic logic [DATA_WIDTH-1:0] fill(input logic [15:0] w);
      return {(DATA_WIDTH/16){w}};
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [15:0] n);
      return ADDR_WIDTH'({n, 3'b000});
   endfunction

`ifdef DDR3_TEST_LFSR_EN
   logic [15:0] wr_lfsr;
   logic [15:0] rd_lfsr;

   // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   assign seed_word    = 16'hACE1;
   assign wr_next_word = lfsr_step(wr_lfsr);
   assign rd_exp_word  = rd_lfsr;
`else
   assign seed_word    = 16'h0000;
   assign wr_next_word = wr_idx + 16'd1;
   assign rd_exp_word  = rx_cnt;
`endif

   assign start_rise = start & ~start_d;
   assign cmd_fire   = cmd_en_q & mem.cmd_ready;
   assign dat_fire   = wr_en_q & mem.wr_data_rdy;
   // a burst needs both halves; either may have been taken earlier
   assign burst_done = (cmd_acc | cmd_fire) & (dat_acc | dat_fire);
   assign running    = (state == WRITE) | (state == READ) | (state == CHECK);
   assign calib_lost = running & ~init_calib_complete;
   assign rx_take    = ((state == READ) | (state == CHECK))
                     & mem.rd_data_valid & (rx_cnt != NB);

   assign mem.cmd         = cmd_q;
   assign mem.cmd_en      = cmd_en_q;
   assign mem.addr        = addr_q;
   assign mem.wr_data     = wr_data_q;
   assign mem.wr_data_en  = wr_en_q;
   assign mem.wr_data_end = wr_en_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (start_rise & init_calib_complete) next_state = WRITE;
         end
         WRITE: begin
            if (burst_done && wr_idx == LAST) next_state = READ;
         end
         READ: begin
            if (cmd_fire && rd_idx == LAST) next_state = CHECK;
         end
         CHECK: begin
            if (rx_cnt == NB) next_state = FINISH;
         end
         FINISH:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (calib_lost) next_state = FINISH;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // held high so a start level present at release is not an edge
         start_d   <= 1'b1;
         wr_idx    <= '0;
         rd_idx    <= '0;
         rx_cnt    <= '0;
         cmd_acc   <= 1'b0;
         dat_acc   <= 1'b0;
         cmd_q     <= CMD_WR;
         cmd_en_q  <= 1'b0;
         addr_q    <= '0;
         wr_data_q <= '0;
         wr_en_q   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_cnt   <= '0;
         last_rd   <= '0;
`ifdef DDR3_TEST_LFSR_EN
         wr_lfsr   <= '0;
         rd_lfsr   <= '0;
`endif
      end else begin
         start_d <= start;
         if (calib_lost) begin
            cmd_en_q <= 1'b0;
            wr_en_q  <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (next_state == WRITE) begin
                     busy      <= 1'b1;
                     done      <= 1'b0;
                     pass      <= 1'b0;
                     err_cnt   <= '0;
                     wr_idx    <= '0;
                     rd_idx    <= '0;
                     rx_cnt    <= '0;
                     cmd_acc   <= 1'b0;
                     dat_acc   <= 1'b0;
                     cmd_q     <= CMD_WR;
                     cmd_en_q  <= 1'b1;
                     addr_q    <= '0;
                     wr_en_q   <= 1'b1;
                     wr_data_q <= fill(seed_word);
`ifdef DDR3_TEST_LFSR_EN
                     wr_lfsr   <= seed_word;
                     rd_lfsr   <= seed_word;
`endif
                  end
               end
               WRITE: begin
                  if (burst_done) begin
                     cmd_acc <= 1'b0;
                     dat_acc <= 1'b0;
                     if (wr_idx == LAST) begin
                        wr_en_q  <= 1'b0;
                        cmd_q    <= CMD_RD;
                        cmd_en_q <= 1'b1;
                        addr_q   <= '0;
                     end else begin
                        wr_idx    <= wr_idx + 16'd1;
                        cmd_en_q  <= 1'b1;
                        wr_en_q   <= 1'b1;
                        addr_q    <= addr_of(wr_idx + 16'd1);
                        wr_data_q <= fill(wr_next_word);
`ifdef DDR3_TEST_LFSR_EN
                        wr_lfsr   <= wr_next_word;
`endif
                     end
                  end else begin
                     if (cmd_fire) begin
                        cmd_en_q <= 1'b0;
                        cmd_acc  <= 1'b1;
                     end
                     if (dat_fire) begin
                        wr_en_q <= 1'b0;
                        dat_acc <= 1'b1;
                     end
                  end
               end
               READ: begin
                  if (cmd_fire) begin
                     if (rd_idx == LAST) begin
                        cmd_en_q <= 1'b0;
                     end else begin
                        rd_idx <= rd_idx + 16'd1;
                        addr_q <= addr_of(rd_idx + 16'd1);
                     end
                  end
               end
               default: ;
            endcase
         end

         if (rx_take) begin
            rx_cnt  <= rx_cnt + 16'd1;
            last_rd <= mem.rd_data[15:0];
            if (mem.rd_data != fill(rd_exp_word) && err_cnt != 16'hFFFF)
               err_cnt <= err_cnt + 16'd1;
`ifdef DDR3_TEST_LFSR_EN
            rd_lfsr <= lfsr_step(rd_lfsr);
`endif
         end

         if (next_state == FINISH && state != FINISH) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= ~calib_lost & (err_cnt == 16'd0);
         end
      end
   end

endmodule

// File: tb/tb_ddr3_test_gen.sv
// Testbench for ddr3_test_gen: scoreboard of expected write/read addresses
// and write data, plus a small memory model returning read beats.
module tb_ddr3_test_gen;
   localparam int AW = 28;
   localparam int DW = 128;
   localparam int NB = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic init_calib_complete = 1'b0;
   logic start = 1'b0;
   logic busy, done, pass;
   logic [15:0] err_cnt, last_rd;

   ddr3_test_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

   ddr3_test_gen #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .NUM_BURSTS(NB)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .init_calib_complete (init_calib_complete),
      .start               (start),
      .mem                 (bus),
      .busy                (busy),
      .done                (done),
      .pass                (pass),
      .err_cnt             (err_cnt),
      .last_rd             (last_rd)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   bit rand_rdy = 1'b0;
   bit corrupt  = 1'b0;
   int n_wcmd = 0, n_wdat = 0, n_rcmd = 0, n_en_cyc = 0, rbeat = 0;

   logic [AW-1:0] exp_waddr_q[$];
   logic [AW-1:0] exp_raddr_q[$];
   logic [DW-1:0] exp_wdata_q[$];
   logic [AW-1:0] wa_q[$];
   logic [DW-1:0] wd_q[$];
   logic [DW-1:0] rq[$];
   logic [DW-1:0] mem_arr[0:NB-1];

   function automatic logic [DW-1:0] pat(input int k);
      logic [15:0] w;
      w = 16'(k);
      return {(DW/16){w}};
   endfunction

   // memory model / scoreboard, driven away from the active edge
   always @(negedge clk) begin
      logic [AW-1:0] a, ea;
      logic [DW-1:0] d, ed;
      int idx;
      if (rst) begin
         rq.delete();
         bus.rd_data_valid = 1'b0;
         bus.rd_data       = '0;
         bus.cmd_ready     = 1'b0;
         bus.wr_data_rdy   = 1'b0;
      end else begin
         if (rq.size() > 0 && (!rand_rdy || $urandom_range(0, 1) == 1)) begin
            bus.rd_data       = rq.pop_front();
            bus.rd_data_valid = 1'b1;
         end else begin
            bus.rd_data_valid = 1'b0;
         end
         bus.cmd_ready   = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.wr_data_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus.cmd_en) n_en_cyc++;
         if (bus.cmd_en && bus.cmd_ready) begin
            a = bus.addr;
            n_cmp++;
            if (bus.cmd == 3'b000) begin
               n_wcmd++;
               if (exp_waddr_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL wr_addr_extra got %h want none", a);
               end else begin
                  ea = exp_waddr_q.pop_front();
                  if (a !== ea) begin
                     n_bad++;
                     $display("FAIL wr_addr got %h want %h", a, ea);
                  end
               end
               wa_q.push_back(a);
            end else if (bus.cmd == 3'b001) begin
               n_rcmd++;
               if (exp_raddr_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL rd_addr_extra got %h want none", a);
               end else begin
                  ea = exp_raddr_q.pop_front();
                  if (a !== ea) begin
                     n_bad++;
                     $display("FAIL rd_addr got %h want %h", a, ea);
                  end
               end
               idx = int'(a[6:3]);
               d = mem_arr[idx];
               if (corrupt && rbeat == 5) d[0] = ~d[0];
               rbeat++;
               rq.push_back(d);
            end else begin
               n_bad++;
               $display("FAIL cmd_code got %b want 000/001", bus.cmd);
            end
         end
         if (bus.wr_data_en && bus.wr_data_rdy) begin
            n_wdat++;
            n_cmp++;
            if (bus.wr_data_end !== 1'b1) begin
               n_bad++;
               $display("FAIL wr_end got %b want 1", bus.wr_data_end);
            end
            if (exp_wdata_q.size() == 0) begin
               n_bad++;
               $display("FAIL wr_data_extra got %h want none", bus.wr_data);
            end else begin
               ed = exp_wdata_q.pop_front();
               if (bus.wr_data !== ed) begin
                  n_bad++;
                  $display("FAIL wr_data got %h want %h", bus.wr_data, ed);
               end
            end
            wd_q.push_back(bus.wr_data);
         end
         while (wa_q.size() > 0 && wd_q.size() > 0) begin
            a = wa_q.pop_front();
            idx = int'(a[6:3]);
            mem_arr[idx] = wd_q.pop_front();
         end
      end
   end

   task automatic start_test();
      exp_waddr_q.delete();
      exp_raddr_q.delete();
      exp_wdata_q.delete();
      wa_q.delete();
      wd_q.delete();
      n_wcmd = 0;
      n_wdat = 0;
      n_rcmd = 0;
      rbeat  = 0;
      for (int k = 0; k < NB; k++) begin
         exp_waddr_q.push_back(AW'(k * 8));
         exp_raddr_q.push_back(AW'(k * 8));
         exp_wdata_q.push_back(pat(k));
      end
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(posedge clk);
         #1;
         if (done && !busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      init_calib_complete = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({bus.cmd_en, bus.wr_data_en, bus.wr_data_end, busy, done, pass} !== 6'b0) begin
         n_bad++;
         $display("FAIL reset_flags got %b want 000000",
                  {bus.cmd_en, bus.wr_data_en, bus.wr_data_end, busy, done, pass});
      end
      n_cmp++;
      if (bus.cmd !== 3'b0 || bus.addr !== '0) begin
         n_bad++;
         $display("FAIL reset_cmd_addr got %b/%h want 000/0", bus.cmd, bus.addr);
      end
      n_cmp++;
      if (bus.wr_data !== '0) begin
         n_bad++;
         $display("FAIL reset_wr_data got %h want 0", bus.wr_data);
      end
      n_cmp++;
      if (err_cnt !== 16'd0 || last_rd !== 16'd0) begin
         n_bad++;
         $display("FAIL reset_cnt got %h/%h want 0/0", err_cnt, last_rd);
      end
      @(negedge clk) rst = 1'b0;
      init_calib_complete = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_basic();
      bit ok;
      rand_rdy = 1'b0;
      corrupt  = 1'b0;
      start_test();
      wait_done(ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL basic_timeout got done=%b want 1", done);
      end
      n_cmp++;
      if (pass !== 1'b1 || err_cnt !== 16'd0) begin
         n_bad++;
         $display("FAIL basic_pass got pass=%b err=%0d want 1/0", pass, err_cnt);
      end
      n_cmp++;
      if (n_wcmd != NB || n_wdat != NB || n_rcmd != NB) begin
         n_bad++;
         $display("FAIL basic_counts got %0d/%0d/%0d want %0d", n_wcmd, n_wdat, n_rcmd, NB);
      end
      n_cmp++;
      if (last_rd !== 16'(NB - 1)) begin
         n_bad++;
         $display("FAIL basic_last_rd got %h want %h", last_rd, 16'(NB - 1));
      end
      n_cmp++;
      if (exp_waddr_q.size() != 0 || exp_raddr_q.size() != 0 || exp_wdata_q.size() != 0) begin
         n_bad++;
         $display("FAIL basic_leftover got %0d/%0d/%0d want 0", exp_waddr_q.size(),
                  exp_raddr_q.size(), exp_wdata_q.size());
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_retain got d=%b p=%b b=%b want 1/1/0", done, pass, busy);
      end
   endtask

   task automatic test_random_ready();
      bit ok;
      rand_rdy = 1'b1;
      start_test();
      wait_done(ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL rand_timeout got done=%b want 1", done);
      end
      n_cmp++;
      if (pass !== 1'b1 || err_cnt !== 16'd0) begin
         n_bad++;
         $display("FAIL rand_pass got pass=%b err=%0d want 1/0", pass, err_cnt);
      end
      n_cmp++;
      if (n_wcmd != NB || n_wdat != NB || n_rcmd != NB) begin
         n_bad++;
         $display("FAIL rand_counts got %0d/%0d/%0d want %0d", n_wcmd, n_wdat, n_rcmd, NB);
      end
      rand_rdy = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_corrupt();
      bit ok;
      corrupt = 1'b1;
      start_test();
      wait_done(ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL corrupt_timeout got done=%b want 1", done);
      end
      n_cmp++;
      if (err_cnt !== 16'd1 || pass !== 1'b0 || done !== 1'b1) begin
         n_bad++;
         $display("FAIL corrupt_result got err=%0d pass=%b done=%b want 1/0/1",
                  err_cnt, pass, done);
      end
      corrupt = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_uncalibrated();
      bit ok;
      int en0;
      @(negedge clk) init_calib_complete = 1'b0;
      repeat (2) @(negedge clk);
      en0 = n_en_cyc;
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (20) @(negedge clk);
      n_cmp++;
      if (n_en_cyc != en0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL uncal_start got en_cycles=%0d busy=%b want 0/0",
                  n_en_cyc - en0, busy);
      end
      init_calib_complete = 1'b1;
      repeat (2) @(negedge clk);
      rand_rdy = 1'b1;
      start_test();
      repeat (4) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1 || n_rcmd != 0) begin
         n_bad++;
         $display("FAIL write_phase got busy=%b reads=%0d want 1/0", busy, n_rcmd);
      end
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_done(ok);
      n_cmp++;
      if (!ok || pass !== 1'b1) begin
         n_bad++;
         $display("FAIL restart_done got done=%b pass=%b want 1/1", done, pass);
      end
      rand_rdy = 1'b0;
      repeat (10) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || n_wcmd != NB || n_rcmd != NB) begin
         n_bad++;
         $display("FAIL no_restart got busy=%b w=%0d r=%0d want 0/%0d/%0d",
                  busy, n_wcmd, n_rcmd, NB, NB);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit seen;
      int en0;
      start_test();
      seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk);
         #1;
         if (bus.cmd_en && bus.cmd == 3'b001) begin
            seen = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!seen) begin
         n_bad++;
         $display("FAIL read_phase_timeout got cmd=%b want 001", bus.cmd);
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({bus.cmd_en, bus.wr_data_en, busy, done, pass} !== 5'b0 ||
          bus.addr !== '0 || err_cnt !== 16'd0 || last_rd !== 16'd0) begin
         n_bad++;
         $display("FAIL midreset_out got en=%b wen=%b b=%b addr=%h err=%h want 0",
                  bus.cmd_en, bus.wr_data_en, busy, bus.addr, err_cnt);
      end
      en0 = n_en_cyc;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (n_en_cyc != en0 || bus.cmd_en !== 1'b0) begin
         n_bad++;
         $display("FAIL midreset_quiet got en_cycles=%0d want 0", n_en_cyc - en0);
      end
      rst = 1'b0;
      wa_q.delete();
      wd_q.delete();
      repeat (6) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || bus.cmd_en !== 1'b0) begin
         n_bad++;
         $display("FAIL no_autostart got busy=%b cmd_en=%b want 0/0", busy, bus.cmd_en);
      end
      start_test();
      wait_done(ok);
      n_cmp++;
      if (!ok || pass !== 1'b1 || err_cnt !== 16'd0) begin
         n_bad++;
         $display("FAIL post_reset got done=%b pass=%b err=%0d want 1/1/0",
                  done, pass, err_cnt);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_calib_loss();
      bit ok;
      rand_rdy = 1'b1;
      start_test();
      repeat (5) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL loss_busy got %b want 1", busy);
      end
      init_calib_complete = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.cmd_en !== 1'b0 || bus.wr_data_en !== 1'b0) begin
         n_bad++;
         $display("FAIL loss_drop got cmd_en=%b wr_en=%b want 0/0",
                  bus.cmd_en, bus.wr_data_en);
      end
      wait_done(ok);
      n_cmp++;
      if (!ok || done !== 1'b1 || pass !== 1'b0) begin
         n_bad++;
         $display("FAIL loss_result got done=%b pass=%b want 1/0", done, pass);
      end
      rand_rdy = 1'b0;
      @(negedge clk) init_calib_complete = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_random_ready();
      test_corrupt();
      test_uncalibrated();
      test_reset_mid();
      test_calib_loss();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ddr3_test_gen.md
DDR3_TEST_GEN -- requirements
Module: ddr3_test_gen

Interface
REQ-001 Parameter ADDR_WIDTH, default 28: width of the controller user address.
REQ-002 Parameter DATA_WIDTH, default 128: user data width; one beat is one BL8 burst of the 16-bit DDR3 bus.
REQ-003 Parameter NUM_BURSTS, default 16, range 1..65535: number of bursts written and then read per test.
REQ-004 clk  input  1: single clock (controller user clock); all logic rises on it.
REQ-005 rst  input  1: asynchronous, active-high reset.
REQ-006 init_calib_complete  input  1: controller calibration done.
REQ-007 start  input  1: test request; acted on at its rising edge.
REQ-008 cmd  output  3: command code, 3'b000 write, 3'b001 read.
REQ-009 cmd_en  output  1: command valid.
REQ-010 cmd_ready  input  1: command accepted when high together with cmd_en.
REQ-011 addr  output  ADDR_WIDTH: burst start address.
REQ-012 wr_data, wr_data_en, wr_data_end  output  DATA_WIDTH/1/1: write beat, valid, last-beat flag.
REQ-013 wr_data_rdy  input  1: write beat accepted when high together with wr_data_en.
REQ-014 rd_data, rd_data_valid  input  DATA_WIDTH/1: returned read beat and valid.
REQ-015 busy, done, pass  output  1 each: test running; test finished; finished with zero errors.
REQ-016 err_cnt  output  16: mismatching read beats, saturating.
REQ-017 last_rd  output  16: low 16 bits of the most recent read beat, for the display stage.

Function
REQ-018 States: IDLE, WRITE, READ, CHECK, FINISH; encoded, one-hot not required.
REQ-019 IDLE->WRITE on a start rising edge while init_calib_complete=1; start edges in other states, or while uncalibrated, are ignored.
REQ-020 On entry to WRITE: clear done, pass, err_cnt, and the burst counters; set busy=1.
REQ-021 Burst n uses address n*8 (BL8 column step), zero-extended to ADDR_WIDTH.
REQ-022 WRITE: cmd=000 with cmd_en is held until cmd_ready; wr_data_en is held until wr_data_rdy; wr_data_end=wr_data_en; cmd_en and wr_data_en are independent.
REQ-023 WRITE: burst n is complete only when both its command and its data beat have been accepted; after burst NUM_BURSTS-1 completes, the next state is READ.
REQ-024 READ: cmd=001 is issued for bursts 0..NUM_BURSTS-1 back-to-back, with one advance per cmd_ready; at the last acceptance the next state is CHECK.
REQ-025 A receive counter counts rd_data_valid beats in READ and CHECK; beat k is compared with pattern(k); each mismatch increments err_cnt, which saturates at 16'hFFFF.
REQ-026 CHECK->FINISH when NUM_BURSTS beats have been received; rd_data_valid in IDLE, WRITE or FINISH is ignored.
REQ-027 FINISH: busy=0, done=1, and pass=(err_cnt==0); this holds for one cycle, then the state returns to IDLE with done and pass retained until the next test starts.
REQ-028 Default pattern(k): DATA_WIDTH/16 copies of the 16-bit value k (incrementing).
REQ-029 last_rd is updated on every accepted rd_data_valid beat in READ or CHECK.
REQ-030 Calibration loss: if init_calib_complete falls while busy, outstanding requests are dropped, cmd_en=wr_data_en=0 on the next cycle, and the FSM goes to FINISH with pass forced to 0.
REQ-031 cmd_en and wr_data_en are registered outputs; no combinational path runs from cmd_ready or wr_data_rdy to cmd_en or wr_data_en.

Reset
REQ-032 While rst=1: state=IDLE; cmd_en, wr_data_en, wr_data_end, busy, done and pass are 0; cmd, addr, wr_data, err_cnt, last_rd and all counters are 0.
REQ-033 Reset asserted mid-test aborts immediately with no further bus requests; no test starts after release until a new start rising edge.

Configuration
REQ-034 Macro DDR3_TEST_LFSR_EN: when defined, pattern(k) is a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) stepped once per burst and replicated across DATA_WIDTH; the write and read sides each reseed at WRITE entry.
REQ-035 Without DDR3_TEST_LFSR_EN, the incrementing pattern of REQ-028 is used and no LFSR logic exists.

Verification
REQ-036 Calibrated, cmd_ready=wr_data_rdy=1, ideal memory, start pulse -> 16 writes at addr 0,8..120, then 16 reads; done=1, pass=1, err_cnt=0.
REQ-037 cmd_ready and wr_data_rdy toggled randomly -> no beat is lost or duplicated; pass=1; every addr/wr_data pair matches burst index.
REQ-038 Memory model corrupts bit 0 of beat 5 -> err_cnt=1, pass=0, done=1.
REQ-039 start pulsed with init_calib_complete=0, then during WRITE -> no commands issued in the first case; no restart in the second.
REQ-040 rst asserted during READ, then start after release -> all outputs 0 during reset; the new test passes with err_cnt=0.
REQ-041 init_calib_complete dropped during WRITE -> cmd_en=0 within 1 cycle; done=1, pass=0.
